// File: rtl/imem_fetch_responder_pkg.sv
// ============================================================================
// Module : imem_fetch_responder_pkg
// Brief  : Shared types and helpers for the instruction-fetch responder.
//          This file is the shared home of the RV32 canonical NOP opcode.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

`ifndef RV32_NOP
`define RV32_NOP 32'h0000_0013
`endif

package imem_fetch_responder_pkg;

  localparam int unsigned XLEN = 32;

  // One fetch response as carried through the latency pipe and response FIFO.
  typedef struct packed {
    logic            err;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_rsp_t;

  localparam int unsigned RSP_W = $bits(fetch_rsp_t);

  // A fetch is in error when it is misaligned or beyond the last RAM word.
  function automatic logic fetch_addr_err(input logic [XLEN-1:0] addr,
                                          input int unsigned     aw);
    logic [XLEN-1:0] hi;
    hi = addr >> (aw + 2);
    return (addr[1:0] != 2'b00) || (hi != '0);
  endfunction

endpackage

`default_nettype wire

// File: rtl/imem_fetch_responder_rsp_fifo.sv
// ============================================================================
// Module : imem_fetch_responder_rsp_fifo
// Brief  : Synchronous first-word-fall-through response FIFO with flush.
//          Capacity is guaranteed by the upstream credit counter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module imem_fetch_responder_rsp_fifo
  import imem_fetch_responder_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       flush_i,
  input  logic       push_i,
  input  fetch_rsp_t data_i,
  input  logic       pop_i,
  output logic       valid_o,
  output fetch_rsp_t data_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] c_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] c_FULL = CNT_W'(DEPTH);

  fetch_rsp_t       mem_q [DEPTH];
  logic [PTR_W-1:0] wptr_q, rptr_q;
  logic [CNT_W-1:0] cnt_q;
  logic             w_push, w_pop;

  assign valid_o = (cnt_q != '0);
  assign data_o  = mem_q[rptr_q];
  assign w_pop   = pop_i & valid_o;
  assign w_push  = push_i;

  // Pointer, occupancy and storage update; flush empties the queue.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else if (flush_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (w_push) begin
        mem_q[wptr_q] <= data_i;
        wptr_q        <= (wptr_q == c_LAST) ? '0 : wptr_q + 1'b1;
      end
      if (w_pop) rptr_q <= (rptr_q == c_LAST) ? '0 : rptr_q + 1'b1;
      case ({w_push, w_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Credits must make an overflowing push impossible.
  a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(push_i && !flush_i && (cnt_q == c_FULL) && !w_pop));

endmodule

`default_nettype wire

// File: rtl/imem_fetch_responder.sv
// ============================================================================
// Module : imem_fetch_responder
// Brief  : Instruction-fetch responder: word RAM, fixed-latency read pipe,
//          credit-limited in-order responses, flush and side load port.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module imem_fetch_responder
  import imem_fetch_responder_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 1024,
  parameter int unsigned LATENCY   = 1,
  parameter int unsigned DEPTH     = 2,
  localparam int unsigned AW       = $clog2(MEM_WORDS)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            flush_i,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [31:0]     req_addr_i,
  output logic            rsp_valid_o,
  input  logic            rsp_ready_i,
  output logic [31:0]     rsp_instr_o,
  output logic [31:0]     rsp_pc_o,
  output logic            rsp_err_o,
  input  logic            ld_en_i,
  input  logic [AW-1:0]   ld_addr_i,
  input  logic [31:0]     ld_data_i
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] c_DEPTH = CNT_W'(DEPTH);

  logic [31:0]      mem_q [MEM_WORDS];
  logic             pipe_vld_q [LATENCY];
  fetch_rsp_t       pipe_dat_q [LATENCY];
  logic [CNT_W-1:0] outstanding_q, outstanding_d;

  logic       w_accept, w_rsp_hs, w_req_err;
  logic       w_tail_vld, w_fifo_valid, w_fifo_push, w_fifo_pop;
  fetch_rsp_t w_tail, w_fifo_data, w_rsp, w_new;

  assign req_ready_o = (outstanding_q < c_DEPTH) & ~flush_i & ~ld_en_i;
  assign w_accept    = req_valid_i & req_ready_o;
  assign w_req_err   = fetch_addr_err(req_addr_i, AW);

  // Erroring requests never touch the RAM and return a NOP instead.
  assign w_new.err   = w_req_err;
  assign w_new.pc    = req_addr_i;
  assign w_new.instr = w_req_err ? `RV32_NOP : mem_q[req_addr_i[2 +: AW]];

  // The pipe tail is shown directly while the FIFO is empty, otherwise it
  // queues behind older responses; the FIFO head always has priority.
  assign w_tail_vld  = pipe_vld_q[LATENCY-1];
  assign w_tail      = pipe_dat_q[LATENCY-1];
  assign rsp_valid_o = w_fifo_valid | w_tail_vld;
  assign w_rsp       = w_fifo_valid ? w_fifo_data : w_tail;
  assign rsp_instr_o = w_rsp.instr;
  assign rsp_pc_o    = w_rsp.pc;
  assign rsp_err_o   = w_rsp.err;
  assign w_rsp_hs    = rsp_valid_o & rsp_ready_i;
  assign w_fifo_pop  = w_fifo_valid & rsp_ready_i;
  assign w_fifo_push = w_tail_vld & ~(~w_fifo_valid & rsp_ready_i);

  // Program load port; RAM contents are intentionally not reset.
  always_ff @(posedge clk_i) begin
    if (ld_en_i) mem_q[ld_addr_i] <= ld_data_i;
  end

  // Fixed-latency read pipe carrying {err, pc, instr}; flush drops all stages.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(LATENCY); i++) begin
        pipe_vld_q[i] <= 1'b0;
        pipe_dat_q[i] <= '0;
      end
    end else begin
      pipe_vld_q[0] <= w_accept & ~flush_i;
      if (w_accept) pipe_dat_q[0] <= w_new;
      for (int i = 1; i < int'(LATENCY); i++) begin
        pipe_vld_q[i] <= pipe_vld_q[i-1] & ~flush_i;
        pipe_dat_q[i] <= pipe_dat_q[i-1];
      end
    end
  end

  // Credit arithmetic: accept adds one, a completed response returns one.
  always_comb begin
    outstanding_d = outstanding_q;
    case ({w_accept, w_rsp_hs})
      2'b10:   outstanding_d = outstanding_q + 1'b1;
      2'b01:   outstanding_d = outstanding_q - 1'b1;
      default: outstanding_d = outstanding_q;
    endcase
  end

  // Credit counter register; flush returns every credit.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)      outstanding_q <= '0;
    else if (flush_i) outstanding_q <= '0;
    else              outstanding_q <= outstanding_d;
  end

  imem_fetch_responder_rsp_fifo #(
    .DEPTH (DEPTH)
  ) u_rsp_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (flush_i),
    .push_i  (w_fifo_push),
    .data_i  (w_tail),
    .pop_i   (w_fifo_pop),
    .valid_o (w_fifo_valid),
    .data_o  (w_fifo_data)
  );

endmodule

`default_nettype wire

// File: tb/tb_imem_fetch_responder.sv
// ============================================================================
// Module : tb_imem_fetch_responder
// Brief  : Directed self-checking bench for imem_fetch_responder.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_imem_fetch_responder;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        flush_i = 1'b0;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic [31:0] req_addr_i = '0;
  logic        rsp_valid_o;
  logic        rsp_ready_i = 1'b0;
  logic [31:0] rsp_instr_o;
  logic [31:0] rsp_pc_o;
  logic        rsp_err_o;
  logic        ld_en_i = 1'b0;
  logic [9:0]  ld_addr_i = '0;
  logic [31:0] ld_data_i = '0;

  int n_checks = 0;
  int n_errors = 0;

  imem_fetch_responder #(
    .MEM_WORDS (1024),
    .LATENCY   (1),
    .DEPTH     (2)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .flush_i     (flush_i),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_addr_i  (req_addr_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .rsp_instr_o (rsp_instr_o),
    .rsp_pc_o    (rsp_pc_o),
    .rsp_err_o   (rsp_err_o),
    .ld_en_i     (ld_en_i),
    .ld_addr_i   (ld_addr_i),
    .ld_data_i   (ld_data_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock edge, then let inputs change 1 ns later.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk_rsp(input string tag, input logic [31:0] pc, input logic [31:0] instr,
                         input logic err);
    chk({tag, ".valid"}, {31'd0, rsp_valid_o}, 32'd1);
    chk({tag, ".pc"},    rsp_pc_o, pc);
    chk({tag, ".instr"}, rsp_instr_o, instr);
    chk({tag, ".err"},   {31'd0, rsp_err_o}, {31'd0, err});
  endtask

  initial begin
    // ---------------- reset ----------------
    #1;
    chk("rst.valid", {31'd0, rsp_valid_o}, 32'd0);
    chk("rst.instr", rsp_instr_o, 32'd0);
    chk("rst.pc",    rsp_pc_o, 32'd0);
    chk("rst.err",   {31'd0, rsp_err_o}, 32'd0);
    tick(); tick();
    rst_ni = 1'b1;
    tick();
    chk("rst.ready", {31'd0, req_ready_o}, 32'd1);

    // ---------------- load program; load blocks accept ----------------
    ld_en_i = 1; ld_addr_i = 10'd0; ld_data_i = 32'h0050_0093;
    req_valid_i = 1; req_addr_i = 32'h0;
    #1 chk("ld.block_ready", {31'd0, req_ready_o}, 32'd0);
    tick();
    req_valid_i = 0;
    ld_addr_i = 10'd1; ld_data_i = 32'h0010_0113;
    tick();
    ld_addr_i = 10'd2; ld_data_i = 32'h0020_8193;
    tick();
    ld_en_i = 0;
    #1 chk("ld.no_rsp", {31'd0, rsp_valid_o}, 32'd0);

    // ---------------- back-to-back fetch ----------------
    rsp_ready_i = 1;
    req_valid_i = 1; req_addr_i = 32'h0;
    #1 chk("b2b.ready0", {31'd0, req_ready_o}, 32'd1);
    tick();
    req_addr_i = 32'h4;
    #1 chk_rsp("b2b.r0", 32'h0, 32'h0050_0093, 1'b0);
    tick();
    req_valid_i = 0;
    #1 chk_rsp("b2b.r1", 32'h4, 32'h0010_0113, 1'b0);
    tick();
    chk("b2b.idle", {31'd0, rsp_valid_o}, 32'd0);

    // ---------------- backpressure ----------------
    rsp_ready_i = 0;
    req_valid_i = 1; req_addr_i = 32'h0;
    tick();
    req_addr_i = 32'h4;
    #1 chk("bp.ready1", {31'd0, req_ready_o}, 32'd1);
    chk_rsp("bp.hold0", 32'h0, 32'h0050_0093, 1'b0);
    tick();
    req_addr_i = 32'h8;
    #1 chk("bp.ready_full", {31'd0, req_ready_o}, 32'd0);
    chk_rsp("bp.hold1", 32'h0, 32'h0050_0093, 1'b0);
    tick();
    rsp_ready_i = 1;
    #1 chk("bp.still_full", {31'd0, req_ready_o}, 32'd0);
    chk_rsp("bp.hold2", 32'h0, 32'h0050_0093, 1'b0);
    tick();
    #1 chk("bp.ready_third", {31'd0, req_ready_o}, 32'd1);
    chk_rsp("bp.r1", 32'h4, 32'h0010_0113, 1'b0);
    tick();
    req_valid_i = 0;
    #1 chk_rsp("bp.r2", 32'h8, 32'h0020_8193, 1'b0);
    tick();
    chk("bp.idle", {31'd0, rsp_valid_o}, 32'd0);

    // ---------------- error responses ----------------
    req_valid_i = 1; req_addr_i = 32'h2;
    tick();
    req_addr_i = 32'h1000;
    #1 chk_rsp("err.misalign", 32'h2, 32'h0000_0013, 1'b1);
    tick();
    req_addr_i = 32'hFFC;
    #1 chk_rsp("err.range", 32'h1000, 32'h0000_0013, 1'b1);
    tick();
    req_valid_i = 0;
    #1 chk("err.last_word_ok", {31'd0, rsp_err_o}, 32'd0);
    chk("err.last_word_pc", rsp_pc_o, 32'hFFC);
    tick();

    // ---------------- flush ----------------
    rsp_ready_i = 0;
    req_valid_i = 1; req_addr_i = 32'h0;
    tick();
    req_addr_i = 32'h4;
    tick();
    flush_i = 1; req_addr_i = 32'h8;
    #1 chk("fl.ready", {31'd0, req_ready_o}, 32'd0);
    tick();
    flush_i = 0; req_valid_i = 0;
    #1 chk("fl.valid", {31'd0, rsp_valid_o}, 32'd0);
    chk("fl.credits", {31'd0, req_ready_o}, 32'd1);
    rsp_ready_i = 1;
    req_valid_i = 1; req_addr_i = 32'h4;
    tick();
    req_valid_i = 0;
    #1 chk_rsp("fl.own", 32'h4, 32'h0010_0113, 1'b0);
    tick();
    chk("fl.idle", {31'd0, rsp_valid_o}, 32'd0);

    // ---------------- load collision ----------------
    ld_en_i = 1; ld_addr_i = 10'd0; ld_data_i = 32'hDEAD_BEEF;
    req_valid_i = 1; req_addr_i = 32'h0;
    #1 chk("col.ready", {31'd0, req_ready_o}, 32'd0);
    tick();
    ld_en_i = 0;
    #1 chk("col.ready2", {31'd0, req_ready_o}, 32'd1);
    tick();
    req_valid_i = 0;
    #1 chk_rsp("col.new", 32'h0, 32'hDEAD_BEEF, 1'b0);
    tick();

    // ---------------- reset mid-traffic ----------------
    rsp_ready_i = 0;
    req_valid_i = 1; req_addr_i = 32'h4;
    tick();
    req_valid_i = 0;
    #1 chk("mr.valid_pre", {31'd0, rsp_valid_o}, 32'd1);
    rst_ni = 0;
    #1 chk("mr.valid", {31'd0, rsp_valid_o}, 32'd0);
    chk("mr.instr", rsp_instr_o, 32'd0);
    chk("mr.pc",    rsp_pc_o, 32'd0);
    chk("mr.err",   {31'd0, rsp_err_o}, 32'd0);
    tick();
    rst_ni = 1;
    tick();
    chk("mr.ready", {31'd0, req_ready_o}, 32'd1);
    chk("mr.no_stray", {31'd0, rsp_valid_o}, 32'd0);
    tick();
    chk("mr.no_stray2", {31'd0, rsp_valid_o}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
